// File: rtl/morph_pkg.sv
// Shared definitions for the morphology kernel controller: kernel indices,
// controller states and the shadow-bank write-mask helper.
package morph_pkg;

  localparam int NUM_KERNELS = 8;

  typedef enum logic [2:0] {
    UP_OP_ERO  = 3'd0,
    UP_OP_DILA = 3'd1,
    UP_CL_ERO  = 3'd2,
    UP_CL_DILA = 3'd3,
    LO_OP_ERO  = 3'd4,
    LO_OP_DILA = 3'd5,
    LO_CL_ERO  = 3'd6,
    LO_CL_DILA = 3'd7
  } kernel_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    SWAP = 2'd2,
    COPY = 2'd3
  } state_e;

  // Bank write-enable mask (bit0 = bank A, bit1 = bank B) for the non-active bank.
  function automatic logic [1:0] shadow_mask(input logic active_bank);
    shadow_mask = active_bank ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/morph_kernel_bank.sv
// One kernel's tap storage for both banks: a shared write port with a per-bank
// enable mask and two asynchronous read ports (filter lookup and bank copy).
module morph_kernel_bank #(
  parameter int KERNEL_WIDTH      = 71,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH        = $clog2(KERNEL_WIDTH)
) (
  input  logic                         clk,
  input  logic [1:0]                   wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [KERNEL_DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_bank_a,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_a,
  output logic [KERNEL_DATA_WIDTH-1:0] rd_data_a,
  input  logic                         rd_bank_b,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_b,
  output logic [KERNEL_DATA_WIDTH-1:0] rd_data_b
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_WIDTH - 1);

  logic [KERNEL_DATA_WIDTH-1:0] mem_r [2][KERNEL_WIDTH];

  // Tap write; both banks may be written together during the clear sweep.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_en[b] && (wr_addr <= LAST_ADDR)) begin
        mem_r[b][wr_addr] <= wr_data;
      end
    end
  end

  // Asynchronous reads; out-of-range taps read as zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a <= LAST_ADDR) begin
      rd_data_a = mem_r[rd_bank_a][rd_addr_a];
    end else begin
      rd_data_a = '0;
    end
    if (rd_addr_b <= LAST_ADDR) begin
      rd_data_b = mem_r[rd_bank_b][rd_addr_b];
    end else begin
      rd_data_b = '0;
    end
  end

endmodule

// File: rtl/morph_kernel_ctrl.sv
// Double-buffered kernel coefficient controller: shadow writes, packet-aligned
// bank swap with a one-cycle stream bubble, then shadow resync by copy.
module morph_kernel_ctrl
  import morph_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int KERNEL_WIDTH      = 71,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int IDLE_TIMEOUT      = 256
) (
  input  logic                                                 clk,
  input  logic                                                 areset_n,
  input  logic                                                 cfg_wr_en,
  input  kernel_e                                              cfg_wr_sel,
  input  logic [$clog2(KERNEL_WIDTH)-1:0]                      cfg_wr_addr,
  input  logic [KERNEL_DATA_WIDTH-1:0]                         cfg_wr_data,
  output logic                                                 cfg_wr_ready,
  output logic                                                 cfg_wr_err,
  input  logic                                                 cfg_commit,
  output logic                                                 cfg_busy,
  output logic                                                 cfg_done,
  input  logic [NUM_KERNELS-1:0][$clog2(KERNEL_WIDTH)-1:0]     lut_addr,
  output logic [NUM_KERNELS-1:0][KERNEL_DATA_WIDTH-1:0]        lut_data,
  input  logic [DATA_WIDTH-1:0]                                s_tdata,
  input  logic                                                 s_tvalid,
  input  logic                                                 s_tlast,
  output logic                                                 s_tready,
  output logic [DATA_WIDTH-1:0]                                m_tdata,
  output logic                                                 m_tvalid,
  input  logic                                                 m_tready
);

  localparam int AW = $clog2(KERNEL_WIDTH);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(KERNEL_WIDTH - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  state_e        state_r;
  logic          bank_sel_r;
  logic          sweep_r;
  logic [IW-1:0] idle_r;
  logic [AW-1:0] idx_r;

  logic swap_s;
  logic hs_s;
  logic addr_ok_s;
  logic cfg_write_s;

  assign swap_s      = (state_r == SWAP);
  assign m_tdata     = s_tdata;
  assign m_tvalid    = s_tvalid & ~swap_s;
  assign s_tready    = m_tready & ~swap_s;
  assign hs_s        = s_tvalid & s_tready;
  assign addr_ok_s   = (cfg_wr_addr <= LAST_ADDR);
  assign cfg_write_s = cfg_wr_en & cfg_wr_ready & addr_ok_s;

  for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
    logic [1:0]                   wen_s;
    logic [AW-1:0]                waddr_s;
    logic [KERNEL_DATA_WIDTH-1:0] wdata_s;
    logic [KERNEL_DATA_WIDTH-1:0] copy_s;
    logic [KERNEL_DATA_WIDTH-1:0] lut_s;

    // Write-port arbitration: clear sweep, then copy, then configuration.
    always_comb begin
      wen_s   = 2'b00;
      waddr_s = idx_r;
      wdata_s = '0;
      if (sweep_r) begin
        wen_s = 2'b11;
      end else if (state_r == COPY) begin
        wen_s   = shadow_mask(bank_sel_r);
        wdata_s = copy_s;
      end else if (cfg_write_s && (cfg_wr_sel == kernel_e'(k))) begin
        wen_s   = shadow_mask(bank_sel_r);
        waddr_s = cfg_wr_addr;
        wdata_s = cfg_wr_data;
      end else begin
        wen_s = 2'b00;
      end
    end

    morph_kernel_bank #(
      .KERNEL_WIDTH      (KERNEL_WIDTH),
      .KERNEL_DATA_WIDTH (KERNEL_DATA_WIDTH)
    ) u_bank (
      .clk       (clk),
      .wr_en     (wen_s),
      .wr_addr   (waddr_s),
      .wr_data   (wdata_s),
      .rd_bank_a (bank_sel_r),
      .rd_addr_a (lut_addr[k]),
      .rd_data_a (lut_s),
      .rd_bank_b (bank_sel_r),
      .rd_addr_b (idx_r),
      .rd_data_b (copy_s)
    );

    // Memory is not yet cleared while sweeping, so hide it from the filter.
    assign lut_data[k] = sweep_r ? '0 : lut_s;
  end

  // Controller FSM with registered status outputs and post-reset clear sweep.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r      <= RUN;
      bank_sel_r   <= 1'b0;
      sweep_r      <= 1'b1;
      idle_r       <= '0;
      idx_r        <= '0;
      cfg_wr_ready <= 1'b0;
      cfg_busy     <= 1'b1;
      cfg_wr_err   <= 1'b0;
      cfg_done     <= 1'b0;
    end else begin
      cfg_wr_err <= cfg_wr_en & (~cfg_wr_ready | ~addr_ok_s);
      cfg_done   <= 1'b0;
      if (sweep_r) begin
        if (idx_r == LAST_ADDR) begin
          sweep_r      <= 1'b0;
          idx_r        <= '0;
          cfg_wr_ready <= 1'b1;
          cfg_busy     <= 1'b0;
        end else begin
          idx_r <= idx_r + 1'b1;
        end
      end else begin
        case (state_r)
          RUN: begin
            if (cfg_commit) begin
              state_r      <= PEND;
              idle_r       <= '0;
              cfg_wr_ready <= 1'b0;
              cfg_busy     <= 1'b1;
            end
          end
          PEND: begin
            if ((hs_s && s_tlast) || (idle_r == IDLE_MAX)) begin
              state_r <= SWAP;
            end else if (hs_s) begin
              idle_r <= '0;
            end else if (idle_r != IDLE_MAX) begin
              idle_r <= idle_r + 1'b1;
            end
          end
          SWAP: begin
            bank_sel_r <= ~bank_sel_r;
            idx_r      <= '0;
            state_r    <= COPY;
          end
          COPY: begin
            if (idx_r == LAST_ADDR) begin
              state_r      <= RUN;
              idx_r        <= '0;
              cfg_done     <= 1'b1;
              cfg_wr_ready <= 1'b1;
              cfg_busy     <= 1'b0;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
          default: begin
            state_r      <= RUN;
            cfg_wr_ready <= 1'b1;
            cfg_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morph_kernel_ctrl.sv
// Scoreboard bench for morph_kernel_ctrl: stream samples carry the expected
// data and lookup taps; a negedge monitor checks every filter-side handshake.
module tb_morph_kernel_ctrl;
  import morph_pkg::*;

  localparam int DW  = 16;
  localparam int KW  = 71;
  localparam int KDW = 8;
  localparam int IT  = 256;

  logic                  clk = 1'b0;
  logic                  areset_n;
  logic                  cfg_wr_en;
  kernel_e               cfg_wr_sel;
  logic [6:0]            cfg_wr_addr;
  logic [KDW-1:0]        cfg_wr_data;
  logic                  cfg_wr_ready;
  logic                  cfg_wr_err;
  logic                  cfg_commit;
  logic                  cfg_busy;
  logic                  cfg_done;
  logic [7:0][6:0]       lut_addr;
  logic [7:0][KDW-1:0]   lut_data;
  logic [DW-1:0]         s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;

  typedef struct {
    logic [DW-1:0]  data;
    logic [KDW-1:0] l0;
    logic [KDW-1:0] l1;
    logic [KDW-1:0] l7;
  } sb_t;

  sb_t sb[$];
  sb_t mon_item;
  int  checks  = 0;
  int  errors  = 0;
  int  bubbles = 0;

  morph_kernel_ctrl #(
    .DATA_WIDTH        (DW),
    .KERNEL_WIDTH      (KW),
    .KERNEL_DATA_WIDTH (KDW),
    .IDLE_TIMEOUT      (IT)
  ) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_sel   (cfg_wr_sel),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_ready (cfg_wr_ready),
    .cfg_wr_err   (cfg_wr_err),
    .cfg_commit   (cfg_commit),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every filter-side handshake pops one expected sample.
  always @(negedge clk) begin
    if (areset_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_sample", 64'(m_tdata), 64'hFFFF_FFFF);
      end else begin
        mon_item = sb.pop_front();
        check("m_tdata", 64'(m_tdata), 64'(mon_item.data));
        check("lut0", 64'(lut_data[0]), 64'(mon_item.l0));
        check("lut1_oob", 64'(lut_data[1]), 64'(mon_item.l1));
        check("lut7", 64'(lut_data[7]), 64'(mon_item.l7));
      end
    end
    if (s_tvalid && !s_tready && m_tready) bubbles++;
  end

  task automatic send(input int n, input int base, input bit last10, input int switch_at,
                      input logic [7:0] old0, input logic [7:0] new0,
                      input logic [7:0] old7, input logic [7:0] new7);
    sb_t it;
    logic ok;
    int w;
    for (int i = 0; i < n; i++) begin
      it.data = DW'(base + i);
      it.l0   = (i < switch_at) ? old0 : new0;
      it.l1   = 8'h00;
      it.l7   = (i < switch_at) ? old7 : new7;
      sb.push_back(it);
      s_tdata  = DW'(base + i);
      s_tlast  = last10 ? ((i % 10) == 9) : (i == n - 1);
      s_tvalid = 1'b1;
      w = 0;
      ok = 1'b0;
      while (!ok && w < 50) begin
        @(negedge clk);
        ok = s_tready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!ok) check("send_timeout", 64'(w), 64'd0);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic cfg_write(input kernel_e sel, input logic [6:0] addr, input logic [7:0] data,
                           output logic err);
    cfg_wr_en   = 1'b1;
    cfg_wr_sel  = sel;
    cfg_wr_addr = addr;
    cfg_wr_data = data;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    err = cfg_wr_err;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (!cfg_done && cnt < bound) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!cfg_done) check("done_timeout", 64'(cnt), 64'(bound + 1));
  endtask

  task automatic wait_ready(input int bound, output int cnt, output int dones);
    cnt = 0;
    dones = 0;
    while (!cfg_wr_ready && cnt < bound) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cfg_done) dones++;
    end
    if (!cfg_wr_ready) check("ready_timeout", 64'(cnt), 64'(bound + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dones;
    logic err;
    areset_n    = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_wr_sel  = UP_OP_ERO;
    cfg_wr_addr = 7'd0;
    cfg_wr_data = 8'd0;
    cfg_commit  = 1'b0;
    s_tdata     = 16'd0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    m_tready    = 1'b1;
    lut_addr    = '0;
    lut_addr[0] = 7'd5;
    lut_addr[1] = 7'd71;

    // Reset values and clear sweep length.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cfg_wr_ready), 64'd0);
    check("rst_busy", 64'(cfg_busy), 64'd1);
    check("rst_err", 64'(cfg_wr_err), 64'd0);
    check("rst_done", 64'(cfg_done), 64'd0);
    check("rst_lut", 64'(lut_data), 64'd0);
    areset_n = 1'b1;
    wait_ready(200, cnt, dones);
    check("sweep_cycles", 64'(cnt), 64'(KW));
    check("sweep_busy_end", 64'(cfg_busy), 64'd0);

    // First commit: shadow write, tlast-triggered swap, write during COPY rejected.
    cfg_write(UP_OP_ERO, 7'd5, 8'hFD, err);
    check("valid_write_err", 64'(err), 64'd0);
    check("shadow_not_active", 64'(lut_data[0]), 64'd0);
    commit();
    check("pend_busy", 64'(cfg_busy), 64'd1);
    check("pend_ready", 64'(cfg_wr_ready), 64'd0);
    send(3, 16'h0100, 1'b0, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    check("swap_tready", 64'(s_tready), 64'd0);
    check("swap_lut_old", 64'(lut_data[0]), 64'd0);
    cnt = 0;
    while (!cfg_done && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 3) begin
        cfg_wr_en   = 1'b1;
        cfg_wr_sel  = UP_OP_ERO;
        cfg_wr_addr = 7'd5;
        cfg_wr_data = 8'd11;
      end
      if (cnt == 4) begin
        cfg_wr_en = 1'b0;
        check("copy_write_err", 64'(cfg_wr_err), 64'd1);
      end
    end
    check("done_latency", 64'(cnt), 64'(KW + 1));
    check("done_ready", 64'(cfg_wr_ready), 64'd1);
    @(posedge clk);
    #1;
    check("done_pulse_end", 64'(cfg_done), 64'd0);
    send(1, 16'h0200, 1'b0, 1, 8'hFD, 8'hFD, 8'h00, 8'h00);

    // Out-of-range tap address rejected in RUN.
    cfg_write(UP_OP_ERO, 7'd71, 8'h55, err);
    check("oob_write_err", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    check("oob_err_pulse_end", 64'(cfg_wr_err), 64'd0);

    // Idle-timeout swap; copy must have preserved the earlier tap.
    cfg_write(LO_CL_DILA, 7'd0, 8'h07, err);
    commit();
    cnt = 0;
    while (s_tready && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("timeout_swap_cycles", 64'(cnt), 64'(IT + 1));
    check("timeout_lut7_old", 64'(lut_data[7]), 64'd0);
    wait_done(200, cnt);
    check("timeout_done_latency", 64'(cnt), 64'(KW + 1));
    send(1, 16'h0300, 1'b0, 1, 8'hFD, 8'hFD, 8'h07, 8'h07);

    // Continuous stream, commit mid-packet: one bubble, swap on packet boundary.
    cfg_write(UP_OP_ERO, 7'd5, 8'd20, err);
    bubbles = 0;
    fork
      send(30, 16'h1000, 1'b1, 10, 8'hFD, 8'd20, 8'h07, 8'h07);
      begin
        repeat (3) @(posedge clk);
        #1;
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
      end
    join
    wait_done(200, cnt);
    check("stream_bubbles", 64'(bubbles), 64'd1);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during COPY abandons the commit; a later commit still works.
    @(posedge clk);
    #1;
    cfg_write(LO_CL_DILA, 7'd0, 8'h09, err);
    commit();
    send(1, 16'h2000, 1'b0, 1, 8'd20, 8'd20, 8'h07, 8'h07);
    repeat (10) @(posedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(cfg_wr_ready), 64'd0);
    check("mid_rst_busy", 64'(cfg_busy), 64'd1);
    check("mid_rst_done", 64'(cfg_done), 64'd0);
    check("mid_rst_lut", 64'(lut_data), 64'd0);
    check("mid_rst_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    wait_ready(200, cnt, dones);
    check("post_rst_sweep", 64'(cnt), 64'(KW));
    check("post_rst_no_done", 64'(dones), 64'd0);
    send(1, 16'h3000, 1'b0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    cfg_write(UP_OP_ERO, 7'd5, 8'd100, err);
    commit();
    send(1, 16'h3100, 1'b0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done(200, cnt);
    check("post_rst_done_latency", 64'(cnt), 64'(KW + 1));
    send(1, 16'h3200, 1'b0, 1, 8'd100, 8'd100, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
